// File: rtl/merge2_avlstrm.sv
// 2:1 packet-atomic Avalon-ST merge with round-robin packet arbitration.
// One registered output stage; per-port sop/eop/drop statistics.
module merge2_avlstrm #(
  parameter int DATA_W  = 512,
  parameter int EMPTY_W = 6,
  parameter int CH_W    = 1
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [DATA_W-1:0]  i_in0_data,
  input  logic               i_in0_valid,
  output logic               o_in0_ready,
  input  logic               i_in0_sop,
  input  logic               i_in0_eop,
  input  logic [EMPTY_W-1:0] i_in0_empty,
  output logic               o_in0_almost_full,
  input  logic [CH_W-1:0]    i_in0_channel,
  input  logic [DATA_W-1:0]  i_in1_data,
  input  logic               i_in1_valid,
  output logic               o_in1_ready,
  input  logic               i_in1_sop,
  input  logic               i_in1_eop,
  input  logic [EMPTY_W-1:0] i_in1_empty,
  output logic               o_in1_almost_full,
  input  logic [CH_W-1:0]    i_in1_channel,
  output logic [DATA_W-1:0]  o_out_data,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic               o_out_sop,
  output logic               o_out_eop,
  output logic [EMPTY_W-1:0] o_out_empty,
  input  logic               i_out_almost_full,
  output logic [CH_W-1:0]    o_out_channel,
  output logic [31:0]        o_stats_in_pkt0,
  output logic [31:0]        o_stats_in_pkt1,
  output logic [31:0]        o_stats_out_pkt,
  output logic [31:0]        o_stats_in_pkt0_s,
  output logic [31:0]        o_stats_in_pkt1_s,
  output logic [31:0]        o_stats_out_pkt_s,
  output logic [31:0]        o_stats_drop
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY0,
    S_BUSY1
  } state_t;

  state_t r_state, w_nstate;
  logic   r_rr, w_nrr;
  logic   w_adv, w_c0, w_c1, w_sel;
  logic   w_rdy0, w_rdy1, w_fwd;
  logic   w_drop0, w_drop1;
  logic   w_eop_sel;
  logic   w_acc0, w_acc1, w_acc_out;
  logic   w_unused;

  logic               r_valid, r_sop, r_eop;
  logic [DATA_W-1:0]  r_data;
  logic [EMPTY_W-1:0] r_empty;
  logic [CH_W-1:0]    r_ch;

  logic [31:0] r_st_in0, r_st_in1, r_st_out;
  logic [31:0] r_st_in0_s, r_st_in1_s, r_st_out_s;
  logic [31:0] r_st_drop;

  assign w_unused = ^{i_in0_channel, i_in1_channel};

  assign w_adv = !r_valid | i_out_ready;
  assign w_c0  = i_in0_valid & i_in0_sop;
  assign w_c1  = i_in1_valid & i_in1_sop;

  // in IDLE, a lone sop wins; with two sops the rr pointer decides
  assign w_sel = (r_state == S_BUSY1) |
                 ((r_state == S_IDLE) & w_c1 & (!w_c0 | r_rr));

  assign w_eop_sel = w_sel ? i_in1_eop : i_in0_eop;

  always_comb begin
    w_nstate = r_state;
    w_nrr    = r_rr;
    w_rdy0   = 1'b0;
    w_rdy1   = 1'b0;
    w_fwd    = 1'b0;
    w_drop0  = 1'b0;
    w_drop1  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_c0 | w_c1) begin
          w_rdy0 = !w_sel & w_adv;
          w_rdy1 = w_sel & w_adv;
          w_fwd  = w_adv;
          if (w_adv) begin
            if (w_eop_sel) w_nrr = !w_sel;
            else w_nstate = w_sel ? S_BUSY1 : S_BUSY0;
          end
        end
        if (i_in0_valid & !i_in0_sop) begin
          w_rdy0  = 1'b1;
          w_drop0 = 1'b1;
        end
        if (i_in1_valid & !i_in1_sop) begin
          w_rdy1  = 1'b1;
          w_drop1 = 1'b1;
        end
      end
      S_BUSY0: begin
        w_rdy0 = w_adv;
        w_fwd  = i_in0_valid & w_adv;
        if (w_fwd & i_in0_eop) begin
          w_nstate = S_IDLE;
          w_nrr    = 1'b1;
        end
      end
      S_BUSY1: begin
        w_rdy1 = w_adv;
        w_fwd  = i_in1_valid & w_adv;
        if (w_fwd & i_in1_eop) begin
          w_nstate = S_IDLE;
          w_nrr    = 1'b0;
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
      r_rr    <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_rr    <= w_nrr;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_empty <= '0;
      r_ch    <= '0;
    end else if (w_fwd) begin
      r_valid <= 1'b1;
      r_data  <= w_sel ? i_in1_data : i_in0_data;
      r_sop   <= w_sel ? i_in1_sop : i_in0_sop;
      r_eop   <= w_eop_sel;
      r_empty <= w_sel ? i_in1_empty : i_in0_empty;
      r_ch    <= CH_W'(w_sel);
    end else if (w_adv) begin
      r_valid <= 1'b0;
    end
  end

  // readies are held low while reset is asserted
  assign o_in0_ready = Rst_n & w_rdy0;
  assign o_in1_ready = Rst_n & w_rdy1;

  assign w_acc0    = i_in0_valid & o_in0_ready;
  assign w_acc1    = i_in1_valid & o_in1_ready;
  assign w_acc_out = r_valid & i_out_ready;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_st_in0   <= '0;
      r_st_in1   <= '0;
      r_st_out   <= '0;
      r_st_in0_s <= '0;
      r_st_in1_s <= '0;
      r_st_out_s <= '0;
      r_st_drop  <= '0;
    end else begin
      if (w_acc0 & i_in0_eop) r_st_in0 <= r_st_in0 + 32'd1;
      if (w_acc1 & i_in1_eop) r_st_in1 <= r_st_in1 + 32'd1;
      if (w_acc_out & r_eop) r_st_out <= r_st_out + 32'd1;
      if (w_acc0 & i_in0_sop) r_st_in0_s <= r_st_in0_s + 32'd1;
      if (w_acc1 & i_in1_sop) r_st_in1_s <= r_st_in1_s + 32'd1;
      if (w_acc_out & r_sop) r_st_out_s <= r_st_out_s + 32'd1;
      if (w_drop0 | w_drop1)
        r_st_drop <= r_st_drop + 32'(w_drop0) + 32'(w_drop1);
    end
  end

  assign o_in0_almost_full = i_out_almost_full;
  assign o_in1_almost_full = i_out_almost_full;

  assign o_out_valid   = r_valid;
  assign o_out_data    = r_data;
  assign o_out_sop     = r_sop;
  assign o_out_eop     = r_eop;
  assign o_out_empty   = r_empty;
  assign o_out_channel = r_ch;

  assign o_stats_in_pkt0   = r_st_in0;
  assign o_stats_in_pkt1   = r_st_in1;
  assign o_stats_out_pkt   = r_st_out;
  assign o_stats_in_pkt0_s = r_st_in0_s;
  assign o_stats_in_pkt1_s = r_st_in1_s;
  assign o_stats_out_pkt_s = r_st_out_s;
  assign o_stats_drop      = r_st_drop;

endmodule

// File: tb/tb_merge2_avlstrm.sv
// Bench for merge2_avlstrm: directed scenarios plus random traffic
// scored against per-source packet queues and counted statistics.
module tb_merge2_avlstrm;
  localparam int DW = 512;
  localparam int EW = 6;
  localparam int CW = 1;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  logic [DW-1:0] i_in0_data, i_in1_data, o_out_data;
  logic i_in0_valid, i_in0_sop, i_in0_eop, o_in0_ready, o_in0_almost_full;
  logic i_in1_valid, i_in1_sop, i_in1_eop, o_in1_ready, o_in1_almost_full;
  logic [EW-1:0] i_in0_empty, i_in1_empty, o_out_empty;
  logic [CW-1:0] i_in0_channel, i_in1_channel, o_out_channel;
  logic o_out_valid, i_out_ready, o_out_sop, o_out_eop, i_out_almost_full;
  logic [31:0] o_stats_in_pkt0, o_stats_in_pkt1, o_stats_out_pkt;
  logic [31:0] o_stats_in_pkt0_s, o_stats_in_pkt1_s, o_stats_out_pkt_s;
  logic [31:0] o_stats_drop;

  merge2_avlstrm dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .i_in0_data(i_in0_data), .i_in0_valid(i_in0_valid),
    .o_in0_ready(o_in0_ready), .i_in0_sop(i_in0_sop),
    .i_in0_eop(i_in0_eop), .i_in0_empty(i_in0_empty),
    .o_in0_almost_full(o_in0_almost_full),
    .i_in0_channel(i_in0_channel),
    .i_in1_data(i_in1_data), .i_in1_valid(i_in1_valid),
    .o_in1_ready(o_in1_ready), .i_in1_sop(i_in1_sop),
    .i_in1_eop(i_in1_eop), .i_in1_empty(i_in1_empty),
    .o_in1_almost_full(o_in1_almost_full),
    .i_in1_channel(i_in1_channel),
    .o_out_data(o_out_data), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_out_sop(o_out_sop),
    .o_out_eop(o_out_eop), .o_out_empty(o_out_empty),
    .i_out_almost_full(i_out_almost_full),
    .o_out_channel(o_out_channel),
    .o_stats_in_pkt0(o_stats_in_pkt0),
    .o_stats_in_pkt1(o_stats_in_pkt1),
    .o_stats_out_pkt(o_stats_out_pkt),
    .o_stats_in_pkt0_s(o_stats_in_pkt0_s),
    .o_stats_in_pkt1_s(o_stats_in_pkt1_s),
    .o_stats_out_pkt_s(o_stats_out_pkt_s),
    .o_stats_drop(o_stats_drop)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
    logic [EW-1:0] e;
  } beat_t;

  beat_t q_in[2][$];
  beat_t q_ex[2][$];
  int    acc[2][$];
  int    ocyc[$];
  int    och[$];

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned m_eop[2], m_sop[2];
  int unsigned m_drop, m_opkt, m_osop;
  int unsigned uid = 1;
  logic cv[2];
  int  vprob, rprob, cyc;
  bit  no_orph, was_stall, in_pkt;
  int  cur_ch;
  logic [DW-1:0] hold_d;
  logic [EW+2:0] hold_m;

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input int len, input bit orph);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      for (int w = 0; w < DW / 32; w++) b.d[w*32+:32] = $urandom;
      b.d[31:0] = uid;
      uid++;
      b.sop = !orph && (i == 0);
      b.eop = orph ? 1'($urandom % 2) : (i == len - 1);
      b.e   = EW'($urandom);
      q_in[k].push_back(b);
      if (!orph) q_ex[k].push_back(b);
      m_eop[k] += b.eop;
      m_sop[k] += b.sop;
      if (orph) m_drop++;
    end
    if (!orph) begin
      m_opkt++;
      m_osop++;
    end
  endtask

  task automatic step();
    int ch;
    beat_t e;
    @(negedge Clk);
    for (int k = 0; k < 2; k++)
      if (!cv[k] && q_in[k].size() > 0 && int'($urandom % 100) < vprob)
        cv[k] = 1'b1;
    i_in0_valid = cv[0];
    i_in1_valid = cv[1];
    i_in0_channel = CW'($urandom);
    i_in1_channel = CW'($urandom);
    if (cv[0]) begin
      i_in0_data = q_in[0][0].d; i_in0_sop = q_in[0][0].sop;
      i_in0_eop = q_in[0][0].eop; i_in0_empty = q_in[0][0].e;
    end
    if (cv[1]) begin
      i_in1_data = q_in[1][0].d; i_in1_sop = q_in[1][0].sop;
      i_in1_eop = q_in[1][0].eop; i_in1_empty = q_in[1][0].e;
    end
    i_out_ready = int'($urandom % 100) < rprob;
    i_out_almost_full = 1'($urandom);
    #4;
    chk("af0", o_in0_almost_full, i_out_almost_full);
    chk("af1", o_in1_almost_full, i_out_almost_full);
    if (was_stall) begin
      chk("hold_v", o_out_valid, 1);
      chk("hold_d", o_out_data, hold_d);
      chk("hold_m", {o_out_sop, o_out_eop, o_out_channel, o_out_empty}, hold_m);
    end
    was_stall = o_out_valid && !i_out_ready;
    hold_d = o_out_data;
    hold_m = {o_out_sop, o_out_eop, o_out_channel, o_out_empty};
    if (no_orph && was_stall)
      chk("stall_rdy", {o_in0_ready, o_in1_ready}, 0);
    if (o_out_valid && i_out_ready) begin
      ch = int'(o_out_channel);
      if (in_pkt) chk("contig", ch, cur_ch);
      if (q_ex[ch].size() == 0) chk("extra_beat", 1, 0);
      else begin
        e = q_ex[ch].pop_front();
        chk("data", o_out_data, e.d);
        chk("sop", o_out_sop, e.sop);
        chk("eop", o_out_eop, e.eop);
        chk("empty", o_out_empty, e.e);
      end
      if (o_out_sop) begin
        in_pkt = 1;
        cur_ch = ch;
      end
      if (o_out_eop) in_pkt = 0;
      ocyc.push_back(cyc);
      och.push_back(ch);
    end
    if (cv[0] && o_in0_ready) begin
      void'(q_in[0].pop_front()); cv[0] = 1'b0; acc[0].push_back(cyc);
    end
    if (cv[1] && o_in1_ready) begin
      void'(q_in[1].pop_front()); cv[1] = 1'b0; acc[1].push_back(cyc);
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    #2;
    Rst_n = 1'b0;
    i_in0_valid = 1'b1; i_in0_sop = 1'b1;
    i_in1_valid = 1'b1; i_in1_sop = 1'b1;
    i_out_ready = 1'b1;
    #1;
    chk("rst_valid", o_out_valid, 0);
    chk("rst_out", {o_out_data, o_out_sop, o_out_eop, o_out_empty, o_out_channel}, 0);
    chk("rst_rdy", {o_in0_ready, o_in1_ready}, 0);
    chk("rst_stats", {o_stats_in_pkt0, o_stats_in_pkt1, o_stats_out_pkt,
        o_stats_in_pkt0_s, o_stats_in_pkt1_s, o_stats_out_pkt_s, o_stats_drop}, 0);
    @(negedge Clk);
    i_in0_valid = 1'b0; i_in1_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      q_in[k].delete(); q_ex[k].delete(); acc[k].delete();
      m_eop[k] = 0; m_sop[k] = 0; cv[k] = 1'b0;
    end
    ocyc.delete(); och.delete();
    m_drop = 0; m_opkt = 0; m_osop = 0;
    was_stall = 0; in_pkt = 0; cyc = 0;
    Rst_n = 1'b1;
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((q_in[0].size() + q_in[1].size() + q_ex[0].size() +
            q_ex[1].size()) > 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", q_in[0].size() + q_in[1].size() +
        q_ex[0].size() + q_ex[1].size(), 0);
    repeat (2) step();
  endtask

  task automatic check_stats();
    chk("st_in_pkt0", o_stats_in_pkt0, m_eop[0]);
    chk("st_in_pkt1", o_stats_in_pkt1, m_eop[1]);
    chk("st_out_pkt", o_stats_out_pkt, m_opkt);
    chk("st_in_pkt0_s", o_stats_in_pkt0_s, m_sop[0]);
    chk("st_in_pkt1_s", o_stats_in_pkt1_s, m_sop[1]);
    chk("st_out_pkt_s", o_stats_out_pkt_s, m_osop);
    chk("st_drop", o_stats_drop, m_drop);
  endtask

  initial begin
    int n;
    i_in0_data = '0; i_in1_data = '0;
    i_in0_valid = 0; i_in1_valid = 0;
    i_in0_sop = 0; i_in0_eop = 0; i_in1_sop = 0; i_in1_eop = 0;
    i_in0_empty = '0; i_in1_empty = '0;
    i_in0_channel = '0; i_in1_channel = '0;
    i_out_ready = 0; i_out_almost_full = 0;
    vprob = 100; rprob = 100; no_orph = 1;
    repeat (2) @(negedge Clk);

    // single 4-beat packet, one-cycle latency
    do_reset();
    push(0, 4, 0);
    run(50);
    chk("t1_n", ocyc.size(), 4);
    if (ocyc.size() == 4 && acc[0].size() == 4)
      for (int i = 0; i < 4; i++) chk("t1_lat", ocyc[i] - acc[0][i], 1);
    check_stats();

    // simultaneous sops: in0 first, then in1 with no gap
    do_reset();
    push(0, 3, 0);
    push(1, 3, 0);
    run(50);
    chk("t2_n", och.size(), 6);
    if (och.size() == 6)
      for (int i = 0; i < 6; i++) begin
        chk("t2_ch", och[i], i / 3);
        chk("t2_gap", ocyc[i] - ocyc[0], i);
      end
    check_stats();

    // back-pressure on a 5-beat packet
    do_reset();
    rprob = 50;
    push(0, 5, 0);
    run(200);
    chk("t3_n", ocyc.size(), 5);
    check_stats();

    // sop on in1 while in0 is mid-packet
    do_reset();
    rprob = 100;
    push(0, 5, 0);
    step();
    step();
    push(1, 3, 0);
    run(50);
    if (acc[0].size() == 5 && acc[1].size() == 3)
      chk("t4_follow", acc[1][0], acc[0][4] + 1);
    else chk("t4_acc", acc[0].size() * 10 + acc[1].size(), 53);
    check_stats();

    // orphan drop, then round-robin of single-beat packets
    do_reset();
    no_orph = 0;
    push(1, 1, 1);
    repeat (5) step();
    chk("t5_drop", o_stats_drop, 1);
    chk("t5_idle", ocyc.size(), 0);
    push(0, 1, 0); push(1, 1, 0);
    push(0, 1, 0); push(1, 1, 0);
    run(50);
    chk("t5_n", och.size(), 4);
    if (och.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("t5_rr", och[i], i % 2);
        chk("t5_gap", ocyc[i] - ocyc[0], i);
      end
    push(0, 1, 1);
    push(1, 1, 1);
    run(50);
    check_stats();

    // random traffic with orphans and back-pressure
    do_reset();
    vprob = 70; rprob = 70;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 30; i++)
        if ($urandom % 7 == 0) push(k, 1, 1);
        else push(k, 1 + int'($urandom % 6), 0);
    run(5000);
    check_stats();

    // reset mid-packet, then counter wrap
    do_reset();
    vprob = 100; rprob = 100; no_orph = 1;
    push(0, 4, 0);
    n = 0;
    while (acc[0].size() < 2 && n < 20) begin
      step();
      n++;
    end
    chk("t6_beats", acc[0].size(), 2);
    do_reset();
    @(negedge Clk);
    force dut.r_st_out = 32'hFFFF_FFFF;
    @(negedge Clk);
    release dut.r_st_out;
    push(0, 2, 0);
    run(50);
    chk("t6_wrap", o_stats_out_pkt, 0);
    chk("t6_wrap_s", o_stats_out_pkt_s, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
